// File: rtl/fdtd_ctrl_pkg.sv
// Shared types and helpers for the Ez sweep controller: FSM states,
// pipeline depth arithmetic and a width-generic saturating signed add.
package fdtd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    localparam int DEF_RD_LATENCY   = 1;
    localparam int DEF_CALC_LATENCY = 4;
    localparam int PIPE_DEPTH       = DEF_RD_LATENCY + 1 + DEF_CALC_LATENCY;

    // Read latency, one operand register stage, then the calculator latency.
    function automatic int pipe_depth(input int rd_lat, input int calc_lat);
        return rd_lat + 1 + calc_lat;
    endfunction

    // Operands arrive sign-extended to 64 bits; the caller truncates to width.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 width
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_val;
        logic signed [63:0] min_val;
        logic signed [63:0] result;
        sum     = a + b;
        max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_val = -(64'sd1 <<< (width - 1));
        if (sum > max_val) begin
            result = max_val;
        end else if (sum < min_val) begin
            result = min_val;
        end else begin
            result = sum;
        end
        return result;
    endfunction

endpackage

// File: rtl/fdtd_valid_pipe.sv
// {valid, addr} tracker that follows each read through memory and calculator
// latency so the write stage knows which cell ez_n belongs to.
module fdtd_valid_pipe #(
    parameter int DEPTH      = 6,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic [DEPTH-1:0]      valid,
    output logic [ADDR_WIDTH-1:0] tail_addr
);

    logic [ADDR_WIDTH-1:0] addr [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr[i] <= '0;
            end
        end else begin
            valid   <= {valid[DEPTH-2:0], in_valid};
            addr[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                addr[i] <= addr[i-1];
            end
        end
    end

    assign tail_addr = addr[DEPTH-1];

endmodule

// File: rtl/fdtd_ez_sweep_ctrl.sv
// Ez sweep sequencer: issues in-order reads of Hy/Ez, feeds the calculator,
// and writes each result back with PEC at cell 0 and a saturating soft source.
module fdtd_ez_sweep_ctrl
    import fdtd_ctrl_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int RD_LATENCY      = 1,
    parameter int CALC_LATENCY    = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start_i,
    input  logic [ADDR_WIDTH-1:0]      num_cells_i,
    input  logic                       src_en_i,
    input  logic [ADDR_WIDTH-1:0]      src_addr_i,
    input  logic [FDTD_DATA_WIDTH-1:0] src_val_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       rd_en_o,
    output logic [ADDR_WIDTH-1:0]      rd_addr_o,
    input  logic [FDTD_DATA_WIDTH-1:0] hy_rd_data_i,
    input  logic [FDTD_DATA_WIDTH-1:0] ez_rd_data_i,
    output logic                       clken_o,
    output logic [FDTD_DATA_WIDTH-1:0] hy_old_o,
    output logic [FDTD_DATA_WIDTH-1:0] ez_old_o,
    input  logic [FDTD_DATA_WIDTH-1:0] ez_n_i,
    output logic                       wr_en_o,
    output logic [ADDR_WIDTH-1:0]      wr_addr_o,
    output logic [FDTD_DATA_WIDTH-1:0] wr_data_o
);

    localparam int D = pipe_depth(RD_LATENCY, CALC_LATENCY);

    sweep_state_t state;
    sweep_state_t state_next;

    logic [ADDR_WIDTH-1:0]      num_cells;
    logic                       src_en;
    logic [ADDR_WIDTH-1:0]      src_addr;
    logic [FDTD_DATA_WIDTH-1:0] src_val;

    logic [D-1:0]          pipe_valid;
    logic [ADDR_WIDTH-1:0] tail_addr;

    logic accept;
    logic last_issue;
    logic upstream_busy;

    assign accept        = (state == IDLE) && start_i;
    assign last_issue    = (rd_addr_o == (num_cells - ADDR_WIDTH'(1)));
    // The tail may still hold the last cell; its write issues on the same edge DONE is entered.
    assign upstream_busy = |pipe_valid[D-2:0];
    assign clken_o       = busy_o;

    fdtd_valid_pipe #(
        .DEPTH      (D),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_valid_pipe (
        .clk       (CLK),
        .clear     (RST),
        .in_valid  (rd_en_o),
        .in_addr   (rd_addr_o),
        .valid     (pipe_valid),
        .tail_addr (tail_addr)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (num_cells_i == '0) ? DONE : SWEEP;
                end
            end
            SWEEP: begin
                if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!upstream_busy) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            num_cells <= '0;
            src_en    <= 1'b0;
            src_addr  <= '0;
            src_val   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            hy_old_o  <= '0;
            ez_old_o  <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            done_o <= (state == DONE);

            if (accept) begin
                num_cells <= num_cells_i;
                src_en    <= src_en_i;
                src_addr  <= src_addr_i;
                src_val   <= src_val_i;
                busy_o    <= 1'b1;
                rd_en_o   <= (num_cells_i != '0);
                rd_addr_o <= '0;
            end else if (state == SWEEP) begin
                if (last_issue) begin
                    rd_en_o <= 1'b0;
                end else begin
                    rd_addr_o <= rd_addr_o + ADDR_WIDTH'(1);
                end
            end

            if (state == DONE) begin
                busy_o <= 1'b0;
            end

            if (pipe_valid[RD_LATENCY-1]) begin
                hy_old_o <= hy_rd_data_i;
                ez_old_o <= ez_rd_data_i;
            end

            // Cell 0 is forced to zero because its Hy[-1] neighbour does not exist.
            wr_en_o <= pipe_valid[D-1];
            if (pipe_valid[D-1]) begin
                wr_addr_o <= tail_addr;
                if (tail_addr == '0) begin
                    wr_data_o <= '0;
                end else if (src_en && (tail_addr == src_addr)) begin
                    wr_data_o <= FDTD_DATA_WIDTH'(sat_add(64'(signed'(ez_n_i)),
                                                          64'(signed'(src_val)),
                                                          FDTD_DATA_WIDTH));
                end else begin
                    wr_data_o <= ez_n_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_fdtd_ez_sweep_ctrl.sv
// Bench for the Ez sweep controller: memory and calculator stand-ins around
// the DUT, directed sweeps, and a write-back scoreboard with its own monitor.
module tb_fdtd_ez_sweep_ctrl;

    localparam int W  = 32;
    localparam int AW = 10;
    localparam int RL = 1;
    localparam int CL = 4;
    localparam int D  = RL + 1 + CL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] num_cells = '0;
    logic          src_en = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [W-1:0]  src_val = '0;
    logic          busy, done, rd_en, clken, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0]  hy_rd_data, ez_rd_data, hy_old, ez_old, ez_n, wr_data;

    logic [W-1:0] hy_mem [16];
    logic [W-1:0] ez_mem [16];
    logic [W-1:0] calc_pipe [CL];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    wr_t           exp_q [$];
    wr_t           exp_w;
    int            total = 0;
    int            bad = 0;
    int            rd_count = 0;
    int            done_count = 0;
    logic [AW-1:0] rd_next = '0;

    fdtd_ez_sweep_ctrl #(
        .FDTD_DATA_WIDTH (W),
        .ADDR_WIDTH      (AW),
        .RD_LATENCY      (RL),
        .CALC_LATENCY    (CL)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .start_i      (start),
        .num_cells_i  (num_cells),
        .src_en_i     (src_en),
        .src_addr_i   (src_addr),
        .src_val_i    (src_val),
        .busy_o       (busy),
        .done_o       (done),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .hy_rd_data_i (hy_rd_data),
        .ez_rd_data_i (ez_rd_data),
        .clken_o      (clken),
        .hy_old_o     (hy_old),
        .ez_old_o     (ez_old),
        .ez_n_i       (ez_n),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data)
    );

    always #5 clk = ~clk;

    // One-cycle read memories and a stand-in calculator computing hy_old - ez_old.
    always @(posedge clk) begin
        if (rd_en) begin
            hy_rd_data <= hy_mem[rd_addr[3:0]];
            ez_rd_data <= ez_mem[rd_addr[3:0]];
        end
        calc_pipe[0] <= hy_old - ez_old;
        for (int j = 1; j < CL; j++) begin
            calc_pipe[j] <= calc_pipe[j-1];
        end
    end
    assign ez_n = calc_pipe[CL-1];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input logic [AW-1:0] addr, input logic [W-1:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (rd_en === 1'b1) begin
            checkOutput("rd_addr", 64'(rd_addr), 64'(rd_next));
            rd_next = rd_next + 10'd1;
            rd_count++;
        end
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL wr_unexpected: got write addr %0d data 0x%0h, expected no write at %0t",
                         wr_addr, wr_data, $time);
            end else begin
                exp_w = exp_q.pop_front();
                checkOutput("wr_addr", 64'(wr_addr), 64'(exp_w.addr));
                checkOutput("wr_data", 64'(wr_data), 64'(exp_w.data));
            end
        end
        if (done === 1'b1) begin
            done_count++;
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] n, input logic se, input logic [AW-1:0] sa,
                                 input logic [W-1:0] sv, input int pulse_at);
        int cycles;
        int exp_cycles;
        exp_cycles = (n == '0) ? 2 : int'(n) + D + 2;
        @(posedge clk);
        #1;
        num_cells = n;
        src_en    = se;
        src_addr  = sa;
        src_val   = sv;
        rd_next   = '0;
        rd_count  = 0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 1;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        checkOutput("clken_after_start", 64'(clken), 64'd1);
        while (done !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == pulse_at) begin
                num_cells = 10'd3;
                start     = 1'b1;
            end else begin
                start     = 1'b0;
                num_cells = n;
            end
        end
        start = 1'b0;
        checkOutput("done_seen", 64'(done), 64'd1);
        checkOutput("sweep_cycles", 64'(cycles), 64'(exp_cycles));
        checkOutput("busy_at_done", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", 64'(done), 64'd0);
        checkOutput("rd_count", 64'(rd_count), 64'(n));
        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic fillLinear();
        for (int i = 0; i < 16; i++) begin
            hy_mem[i] = 32'(i * 20);
            ez_mem[i] = 32'(i * 4);
        end
    endtask

    task automatic fillConst(input logic [W-1:0] v);
        for (int i = 0; i < 16; i++) begin
            hy_mem[i] = v;
            ez_mem[i] = '0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish before 500000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_rd_en", 64'(rd_en), 64'd0);
        checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
        checkOutput("rst_clken", 64'(clken), 64'd0);
        checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
        checkOutput("rst_hy_old", 64'(hy_old), 64'd0);
        rst = 1'b0;

        $display("[TB] N=8, no source, ez_n = 16*addr");
        fillLinear();
        for (int i = 0; i < 8; i++) begin
            pushExp(10'(i), 32'(i * 16));
        end
        applyStimulus(10'd8, 1'b0, 10'd0, 32'd0, 0);

        $display("[TB] N=4, source +5 at cell 2, ez_n = 100");
        fillConst(32'd100);
        pushExp(10'd0, 32'd0);
        pushExp(10'd1, 32'd100);
        pushExp(10'd2, 32'd105);
        pushExp(10'd3, 32'd100);
        applyStimulus(10'd4, 1'b1, 10'd2, 32'd5, 0);

        $display("[TB] positive saturation");
        fillConst(32'd7);
        hy_mem[1] = 32'h7FFF_FFF0;
        pushExp(10'd0, 32'd0);
        pushExp(10'd1, 32'h7FFF_FFFF);
        pushExp(10'd2, 32'd7);
        applyStimulus(10'd3, 1'b1, 10'd1, 32'h0000_0020, 0);

        $display("[TB] negative saturation");
        hy_mem[1] = 32'h8000_0005;
        pushExp(10'd0, 32'd0);
        pushExp(10'd1, 32'h8000_0000);
        pushExp(10'd2, 32'd7);
        applyStimulus(10'd3, 1'b1, 10'd1, 32'hFFFF_FFF0, 0);

        $display("[TB] source beyond N and source on PEC cell");
        fillLinear();
        pushExp(10'd0, 32'd0);
        pushExp(10'd1, 32'd16);
        pushExp(10'd2, 32'd32);
        applyStimulus(10'd3, 1'b1, 10'd5, 32'd1000, 0);
        pushExp(10'd0, 32'd0);
        pushExp(10'd1, 32'd16);
        pushExp(10'd2, 32'd32);
        applyStimulus(10'd3, 1'b1, 10'd0, 32'd9, 0);

        $display("[TB] N=0");
        applyStimulus(10'd0, 1'b0, 10'd0, 32'd0, 0);

        $display("[TB] start during SWEEP is ignored");
        for (int i = 0; i < 8; i++) begin
            pushExp(10'(i), 32'(i * 16));
        end
        applyStimulus(10'd8, 1'b0, 10'd0, 32'd0, 3);

        $display("[TB] reset at third write aborts the sweep");
        for (int i = 0; i < 3; i++) begin
            pushExp(10'(i), 32'(i * 16));
        end
        @(posedge clk);
        #1;
        num_cells = 10'd8;
        src_en    = 1'b0;
        rd_next   = '0;
        rd_count  = 0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (!((wr_en === 1'b1) && (wr_addr == 10'd2)) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("abort_third_write_seen", 64'((wr_en === 1'b1) && (wr_addr == 10'd2)), 64'd1);
        rst        = 1'b1;
        done_count = 0;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_rd_en", 64'(rd_en), 64'd0);
        checkOutput("abort_rd_addr", 64'(rd_addr), 64'd0);
        checkOutput("abort_wr_en", 64'(wr_en), 64'd0);
        checkOutput("abort_wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("abort_wr_data", 64'(wr_data), 64'd0);
        checkOutput("abort_hy_old", 64'(hy_old), 64'd0);
        checkOutput("abort_ez_old", 64'(ez_old), 64'd0);
        checkOutput("abort_clken", 64'(clken), 64'd0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 64'(done_count), 64'd0);
        checkOutput("abort_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] fresh sweep after abort");
        fillConst(32'd100);
        pushExp(10'd0, 32'd0);
        pushExp(10'd1, 32'd100);
        pushExp(10'd2, 32'd105);
        pushExp(10'd3, 32'd100);
        applyStimulus(10'd4, 1'b1, 10'd2, 32'd5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
